// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-addressed register file; register 0 is a read-only device ID.
// The bus side supports burst writes and repeated-START burst reads with an auto-incrementing pointer.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h1D,
    parameter int         NUM_REGS    = 64,
    parameter logic [7:0] DEVID_VALUE = 8'hE5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] dbg_state
);

    localparam int AW = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    logic r_scl_s1, r_scl_s2, r_scl_d;
    logic r_sda_s1, r_sda_s2, r_sda_d;
    logic r_start, r_stop, r_rise, r_fall, r_bit;
    logic w_start, w_stop, w_scl_rise, w_scl_fall;

    // Synchronizers idle high so reset never fabricates a bus event.
    assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_scl_rise = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall = ~r_scl_s2 & r_scl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
            r_start  <= 1'b0; r_stop   <= 1'b0;
            r_rise   <= 1'b0; r_fall   <= 1'b0; r_bit <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;    r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
            r_sda_s1 <= sda_i;    r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
            r_start  <= w_start;  r_stop   <= w_stop;
            r_rise   <= w_scl_rise;
            r_fall   <= w_scl_fall;
            r_bit    <= r_sda_s2;
        end
    end

    state_t          r_state;
    logic [3:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [AW-1:0]   r_ptr;
    logic            r_rw;
    logic            r_sda_oe, r_busy, r_wr_valid;
    logic [7:0]      r_wr_addr, r_wr_data;
    logic [7:0]      r_regs [NUM_REGS];
    logic [7:0]      w_byte, w_rdata;
    logic            w_match;
    logic            w_unused_host_hi;

    assign w_byte           = {r_shift[6:0], r_bit};
    assign w_match          = (w_byte[7:1] == DEV_ADDR);
    assign w_rdata          = (r_ptr == '0) ? DEVID_VALUE : r_regs[r_ptr];
    assign w_unused_host_hi = ^host_addr;

    // wr_valid is a one-cycle strobe with no ready: wr_addr/wr_data are valid only while it is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 4'd0;
            r_shift    <= 8'd0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'd0;
            r_wr_data  <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'd0;
        end else begin
            r_wr_valid <= 1'b0;
            if (host_we && host_addr[AW-1:0] != '0)
                r_regs[host_addr[AW-1:0]] <= host_wdata;
            if (r_start) begin
                r_state  <= S_ADDR;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
            end else if (r_stop) begin
                r_state  <= S_IDLE;
                r_bitcnt <= 4'd0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_REG, S_WDATA: begin
                        if (r_rise && r_bitcnt != 4'd8) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                if (r_state == S_ADDR) begin
                                    r_busy <= w_match;
                                    r_rw   <= w_byte[0];
                                    if (!w_match) r_state <= S_WAIT_STOP;
                                end else if (r_state == S_REG) begin
                                    r_ptr <= w_byte[AW-1:0];
                                end else begin
                                    // Register 0 is read-only: the byte is still ACKed.
                                    if (r_ptr != '0) begin
                                        r_regs[r_ptr] <= w_byte;
                                        r_wr_valid    <= 1'b1;
                                        r_wr_addr     <= 8'(r_ptr);
                                        r_wr_data     <= w_byte;
                                    end
                                    r_ptr <= r_ptr + AW'(1);
                                end
                            end
                        end else if (r_fall && r_bitcnt == 4'd8) begin
                            r_sda_oe <= 1'b1;
                            r_bitcnt <= 4'd0;
                            r_state  <= (r_state == S_ADDR) ? S_ADDR_ACK :
                                        (r_state == S_REG)  ? S_REG_ACK  : S_WDATA_ACK;
                        end
                    end
                    S_ADDR_ACK: begin
                        if (r_fall) begin
                            r_bitcnt <= 4'd0;
                            if (r_rw) begin
                                r_state  <= S_RDATA;
                                r_shift  <= w_rdata;
                                r_sda_oe <= ~w_rdata[7];
                            end else begin
                                r_state  <= S_REG;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end
                    S_REG_ACK, S_WDATA_ACK: begin
                        if (r_fall) begin
                            r_state  <= S_WDATA;
                            r_sda_oe <= 1'b0;
                        end
                    end
                    S_RDATA: begin
                        if (r_rise && r_bitcnt != 4'd8) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end else if (r_fall && r_bitcnt == 4'd8) begin
                            r_sda_oe <= 1'b0;
                            r_ptr    <= r_ptr + AW'(1);
                            r_state  <= S_RDATA_ACK;
                        end else if (r_fall && r_bitcnt != 4'd0) begin
                            r_sda_oe <= ~r_shift[7];
                        end
                    end
                    S_RDATA_ACK: begin
                        if (r_rise && r_bit) begin
                            r_state <= S_WAIT_STOP;
                        end else if (r_fall) begin
                            r_state  <= S_RDATA;
                            r_bitcnt <= 4'd0;
                            r_shift  <= w_rdata;
                            r_sda_oe <= ~w_rdata[7];
                        end
                    end
                    S_IDLE, S_WAIT_STOP: r_sda_oe <= 1'b0;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_oe    = r_sda_oe;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-level I2C master, open-drain bus, array-based register map model.
module tb_i2c_target_regfile;
  localparam int QC = 6;
  localparam int NREGS = 64;
  localparam logic [3:0] ST_IDLE = 4'd0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic host_we = 1'b0;
  logic [7:0] host_addr = 8'd0;
  logic [7:0] host_wdata = 8'd0;
  logic sda_oe, wr_valid, busy;
  logic [7:0] wr_addr, wr_data;
  logic [3:0] dbg_state;
  logic sda_line;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_regfile dut (
    .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int obs_idx = 0;
  int oe_cnt = 0;
  logic [7:0] m_regs[NREGS];
  int m_ptr = 0;
  logic [7:0] wd_q[$];
  logic [7:0] rd_q[$];

  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'd0;
    m_ptr = 0;
    exp_q.delete();
  endfunction

  function automatic void model_write(input logic [7:0] d);
    if (m_ptr != 0) begin
      m_regs[m_ptr] = d;
      exp_q.push_back({8'(m_ptr), d});
    end
    m_ptr = (m_ptr + 1) % NREGS;
  endfunction

  function automatic logic [7:0] model_read();
    logic [7:0] r;
    r = (m_ptr == 0) ? 8'hE5 : m_regs[m_ptr];
    m_ptr = (m_ptr + 1) % NREGS;
    return r;
  endfunction

  task automatic wq(input int n = 1);
    repeat (n * QC) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); m_sda = 1'b0; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(); m_scl = 1'b1; wq(); m_sda = 1'b1; wq(2);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda = b[i]; wq(); m_scl = 1'b1; wq(2); m_scl = 1'b0; wq();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    m_sda = 1'b1; wq(); m_scl = 1'b1; wq(); a = sda_line; wq(); m_scl = 1'b0; wq();
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(); m_scl = 1'b1; wq(); b[i] = sda_line; wq(); m_scl = 1'b0;
    end
    wq(); m_sda = nack; wq(); m_scl = 1'b1; wq(2); m_scl = 1'b0; wq(); m_sda = 1'b1;
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    if ((a % NREGS) != 0) m_regs[a % NREGS] = d;
  endtask

  task automatic check_wr(input string tag);
    wq(2);
    check({tag, "_wr_cnt"}, obs_q.size() - obs_idx, exp_q.size());
    while (exp_q.size() > 0 && obs_idx < obs_q.size()) begin
      check({tag, "_wr"}, obs_q[obs_idx], exp_q.pop_front());
      obs_idx++;
    end
    obs_idx = obs_q.size();
    exp_q.delete();
  endtask

  task automatic bus_write(input logic [7:0] ra, input string tag);
    logic a;
    i2c_start();
    send_byte(8'h3A, a); check({tag, "_aack"}, a, 0);
    check({tag, "_busy"}, busy, 1);
    send_byte(ra, a); check({tag, "_rack"}, a, 0);
    m_ptr = ra % NREGS;
    foreach (wd_q[i]) begin
      send_byte(wd_q[i], a); check({tag, "_dack"}, a, 0);
      model_write(wd_q[i]);
    end
    i2c_stop();
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
    check_wr(tag);
  endtask

  task automatic bus_read(input logic [7:0] ra, input int n, input bit set_ptr, input string tag);
    logic a;
    logic [7:0] b, e;
    rd_q.delete();
    i2c_start();
    if (set_ptr) begin
      send_byte(8'h3A, a); check({tag, "_waack"}, a, 0);
      send_byte(ra, a); check({tag, "_rack"}, a, 0);
      m_ptr = ra % NREGS;
      i2c_start();
    end
    send_byte(8'h3B, a); check({tag, "_raack"}, a, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      e = model_read();
      check({tag, "_rd"}, b, e);
      rd_q.push_back(b);
    end
    check({tag, "_released"}, sda_oe, 0);
    check({tag, "_busy"}, busy, 1);
    i2c_stop();
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_idle"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    logic a;
    int c0, op, n;
    logic [7:0] ra;
    model_reset();

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    wq(2);

    // Single write then readback
    wd_q = '{8'h08};
    bus_write(8'h2D, "wr2d");
    bus_read(8'h2D, 1, 1'b1, "rd2d");
    check("rd2d_val", rd_q[0], 8'h08);

    // Device ID
    bus_read(8'h00, 1, 1'b1, "devid");
    check("devid_val", rd_q[0], 8'hE5);

    // Wrong address: no ACK, SDA never pulled
    c0 = oe_cnt;
    i2c_start();
    send_byte(8'hA6, a);
    check("wrong_nack", a, 1);
    check("wrong_busy", busy, 0);
    send_bits(8'h5A, 8);
    i2c_stop();
    check("wrong_oe_quiet", oe_cnt - c0, 0);
    wd_q = '{8'h5A};
    bus_write(8'h10, "after_wrong");

    // Burst read wrapping into register 0; upper host address bit ignored
    host_write(8'h3E, 8'h11);
    host_write(8'h7F, 8'h22);
    bus_read(8'h3E, 3, 1'b1, "burst");
    check("burst_b0", rd_q[0], 8'h11);
    check("burst_b1", rd_q[1], 8'h22);
    check("burst_b2", rd_q[2], 8'hE5);

    // STOP after 4 bits of a data byte
    i2c_start();
    send_byte(8'h3A, a);
    send_byte(8'h2D, a);
    send_bits(8'hF0, 4);
    i2c_stop();
    check("partial_idle", dbg_state, ST_IDLE);
    check_wr("partial");
    wd_q = '{8'h55};
    bus_write(8'h00, "wr_reg0");
    bus_read(8'h00, 1, 1'b1, "reg0_after");
    check("reg0_val", rd_q[0], 8'hE5);
    bus_read(8'h2D, 1, 1'b1, "rd2d_keep");
    check("rd2d_keep_val", rd_q[0], 8'h08);

    // Repeated START in the middle of a data byte aborts it
    i2c_start();
    send_byte(8'h3A, a);
    send_byte(8'h20, a);
    send_bits(8'h77, 5);
    wd_q = '{8'h99};
    bus_write(8'h21, "abort");
    bus_read(8'h20, 2, 1'b1, "abort_rd");

    // Write burst wrapping past the top register into read-only 0
    wd_q = '{8'hAA, 8'hBB, 8'hCC};
    bus_write(8'h3F, "wrwrap");
    bus_read(8'h3F, 3, 1'b1, "wrwrap_rd");

    // Randomized traffic
    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 3);
      ra = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      case (op)
        0: host_write(ra, 8'($urandom));
        1: begin
          wd_q.delete();
          for (int k = 0; k < n; k++) wd_q.push_back(8'($urandom));
          bus_write(ra, "rnd_wr");
        end
        2: bus_read(ra, n, 1'b1, "rnd_rd");
        default: bus_read(8'h00, n, 1'b0, "rnd_rdcur");
      endcase
    end

    // Reset while driving a 0 data bit
    host_write(8'h30, 8'h00);
    i2c_start();
    send_byte(8'h3A, a);
    send_byte(8'h30, a);
    i2c_start();
    send_byte(8'h3B, a);
    check("drv0_oe", sda_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    i2c_stop();
    check("rst_mid_busy", busy, 0);
    bus_read(8'h00, 1, 1'b0, "ptr_after_rst");
    check("ptr_after_rst_val", rd_q[0], 8'hE5);
    bus_read(8'h2D, 1, 1'b1, "regs_after_rst");
    check("regs_after_rst_val", rd_q[0], 8'h00);
    check_wr("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable I2C target (responder) exposing a byte-addressed register file on the two-wire bus. It is the far end of our I2C controller and emulates the accelerometer's register map, so controller transactions can be closed-loop tested in simulation and on the board. Register contents are loaded from the local side, for example by a sensor-data generator. The bus side supports single and burst writes, and reads via repeated START with an auto-incrementing register pointer.

## Interface
Parameters:
- `DEV_ADDR`, 7'h1D: 7-bit target address matched on the bus.
- `NUM_REGS`, 64: register count (power of two, 2..256); pointer wraps modulo `NUM_REGS`.
- `DEVID_VALUE`, 8'hE5: constant returned by register 0, which is read-only.

Ports:
- `clk` in 1: system clock, at least 20× the SCL frequency.
- `rst` in 1: reset; synchronous, active-high.
- `scl_i` in 1: raw SCL pin level (asynchronous).
- `sda_i` in 1: raw SDA pin level (asynchronous).
- `sda_oe` out 1: 1 = pull SDA low; 0 = release. The block is open-drain and never drives high.
- `host_we` in 1: local write strobe into the register file.
- `host_addr` in 8: local write address; bits at or above log2(`NUM_REGS`) are ignored.
- `host_wdata` in 8: local write data.
- `wr_valid` out 1: one-cycle pulse per byte written over the bus.
- `wr_addr` out 8: register address of that byte.
- `wr_data` out 8: data of that byte.
- `busy` out 1: high from address match until STOP, or until a START that does not re-address this target.
- `dbg_state` out 4: current FSM state encoding.

## Operation
Bus sampling:
- `scl_i` and `sda_i` each pass through a 2-flop synchronizer, then a history flop for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both take priority over data events in the same cycle.
- Data bits are sampled on SCL rising edges.
- `sda_oe` changes only in the cycle after a detected SCL falling edge.

FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START in any state: go to ADDR, clear the bit counter, release SDA. The register pointer is kept.
- STOP in any state: go to IDLE, release SDA, discard any partial byte.
- ADDR: shift 8 bits, MSB first.
  - Upper 7 bits ≠ `DEV_ADDR`: go to WAIT_STOP, no ACK.
  - Match: drive ACK. R/W=0 leads to REG; R/W=1 leads to RDATA.
- ACK slot: assert `sda_oe` on the falling edge after bit 8; release on the next falling edge.
- REG: the received byte becomes the pointer (modulo `NUM_REGS`). ACK, then go to WDATA.
- WDATA: on each received byte:
  - ACK it.
  - If pointer ≠ 0, write the register and pulse `wr_valid` with `wr_addr`=pointer, `wr_data`=byte.
  - If pointer = 0, the write is discarded silently but still ACKed.
  - Increment the pointer; repeat.
- RDATA:
  - Load a shift register from regs[pointer] (register 0 reads `DEVID_VALUE`) on the falling edge that ends the address ACK, or the falling edge that ends the previous master ACK.
  - Drive each bit as `sda_oe` = ~bit, MSB first; release after bit 8.
  - Sample the master's acknowledge on the next rising edge.
  - Increment the pointer after each byte.
  - Master ACK (0): load the next byte. Master NACK (1): go to WAIT_STOP.
- WAIT_STOP: SDA released; wait for START or STOP.
- Host port writes the register file on any cycle `host_we`=1, except address 0. If a bus write hits the same register in the same cycle, the bus write wins.
- Reset values:
  - `sda_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - State IDLE, pointer 0, all registers 0 (register 0 still reads `DEVID_VALUE`).

## Timing
- Pin-to-detection latency is 3 clk. `sda_oe` updates 4 clk after the pin-level SCL falling edge, which satisfies the I2C zero-hold requirement.
- `wr_valid` pulses 1 clk after the SCL rising edge that samples bit 8 of a data byte.
- A byte read over the bus is snapshotted at load time. A host write after the load is visible only on the next read of that register.
- Pointer wraps from `NUM_REGS`-1 to 0 in both read and write bursts.
- A repeated START in the middle of a byte aborts that byte, with no write and no `wr_valid`.
- `rst` asserted mid-transfer: `sda_oe`=0 on the next clk edge, even while the block is driving ACK or a data 0.

## Test plan
- Write to 0x1D: START, 0x3A, 0x2D, 0x08, STOP → three ACKs; `wr_valid` once with `wr_addr`=0x2D, `wr_data`=0x08; a subsequent read of 0x2D returns 0x08.
- Read DEVID: START, 0x3A, 0x00, repeated START, 0x3B, read 1 byte, master NACK, STOP → returns 0xE5; SDA released after the NACK; `busy` falls at STOP.
- Wrong address 0x53 (byte 0xA6) → no ACK; `sda_oe` stays 0 until STOP; an immediately following 0x1D write succeeds.
- Burst read with host preload 0x3E=0x11, 0x3F=0x22: set pointer 0x3E, read 3 bytes with ACK, ACK, NACK → returns 0x11, 0x22, 0xE5 (wrap to register 0).
- STOP after 4 bits of a WDATA byte → no `wr_valid`, register unchanged, state IDLE; a write to register 0 is ACKed and 0x00 still reads 0xE5.
- `rst` pulsed while the block is driving a 0 data bit → `sda_oe`=0 the next cycle; state IDLE; pointer 0; register contents cleared.
